// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } mem_size_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_DBG = 1;

   typedef struct packed {
      logic [9:0]  addr;
      logic        we;
      logic [31:0] wdata;
      mem_size_t   size;
      logic        sign;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way combinational picker; i_prio selects the port that wins a tie
module dmem_arb_pick (
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic [1:0] o_winner,
   output logic       o_valid
);

   always_comb begin
      o_winner = i_req;
      if (i_req == 2'b11) begin
         o_winner = i_prio ? 2'b10 : 2'b01;
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter/sequencer, one access per two cycles
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed port-0 priority otherwise.
module dmem_arbiter
   import dmem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_i,
   input  logic [1:0][9:0]  addr_i,
   input  logic [1:0]       we_i,
   input  logic [1:0][31:0] wdata_i,
   input  logic [1:0][1:0]  size_i,
   input  logic [1:0]       sign_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic [9:0]       mem_addr_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_wdata_o,
   output logic [1:0]       mem_size_o,
   output logic             mem_sign_o,
   input  logic [31:0]      mem_rdata_i
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   dmem_req_t   r_req;
   dmem_req_t   w_req_sel;
   logic        r_port;
   logic        r_mem_we;
   logic        r_err;
   logic [1:0]  r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  w_winner;
   logic [1:0]  w_gnt;
   logic        w_valid;
   logic        w_prio;
   logic        w_win_port;
   logic        w_latch;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic r_rr_ptr;

   // The port that just lost (or did not ask) gets the next tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= 1'b0;
      end else if (w_latch) begin
         r_rr_ptr <= ~w_win_port;
      end
   end

   assign w_prio = r_rr_ptr;
`else
   assign w_prio = 1'b0;
`endif

   dmem_arb_pick u_pick (
      .i_req    (req_i),
      .i_prio   (w_prio),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_win_port = w_winner[PORT_DBG];

   always_comb begin
      w_req_sel.addr  = addr_i[w_win_port];
      w_req_sel.we    = we_i[w_win_port];
      w_req_sel.wdata = wdata_i[w_win_port];
      w_req_sel.size  = mem_size_t'(size_i[w_win_port]);
      w_req_sel.sign  = sign_i[w_win_port];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 2'b00;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_latch     = 1'b1;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            w_gnt[r_port] = 1'b1;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // mem_we is only ever high during ACCESS so an async reset kills the write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_req    <= '{addr: '0, we: 1'b0, wdata: '0, size: SIZE_WORD, sign: 1'b0};
         r_port   <= 1'b0;
         r_mem_we <= 1'b0;
         r_rvalid <= 2'b00;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rvalid <= 2'b00;
         r_mem_we <= 1'b0;
         if (w_latch) begin
            r_req    <= w_req_sel;
            r_port   <= w_win_port;
            r_mem_we <= w_req_sel.we && (w_req_sel.size != SIZE_ILL);
         end
         if (r_state == ACCESS) begin
            r_rvalid <= w_gnt;
            r_err    <= (r_req.size == SIZE_ILL);
            r_rdata  <= (!r_req.we && (r_req.size != SIZE_ILL)) ? mem_rdata_i : '0;
         end
      end
   end

   assign gnt_o       = w_gnt;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign err_o       = r_err;
   assign mem_addr_o  = r_req.addr;
   assign mem_we_o    = r_mem_we;
   assign mem_wdata_o = r_req.wdata;
   assign mem_size_o  = r_req.size;
   assign mem_sign_o  = r_req.sign;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with byte-level reference model
module tb_dmem_arbiter;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       req_i;
   logic [1:0][9:0]  addr_i;
   logic [1:0]       we_i;
   logic [1:0][31:0] wdata_i;
   logic [1:0][1:0]  size_i;
   logic [1:0]       sign_i;
   logic [1:0]       gnt_o;
   logic [1:0]       rvalid_o;
   logic [31:0]      rdata_o;
   logic             err_o;
   logic [9:0]       mem_addr_o;
   logic             mem_we_o;
   logic [31:0]      mem_wdata_o;
   logic [1:0]       mem_size_o;
   logic             mem_sign_o;
   logic [31:0]      mem_rdata_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_i       (req_i),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .wdata_i     (wdata_i),
      .size_i      (size_i),
      .sign_i      (sign_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .mem_addr_o  (mem_addr_o),
      .mem_we_o    (mem_we_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_size_o  (mem_size_o),
      .mem_sign_o  (mem_sign_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // Memory attached to the arbiter: 256 x 32-bit words, little-endian, wrapping.
   logic [31:0] sim_mem [256] = '{default: '0};

   always_comb begin
      logic [31:0] raw;
      logic [9:0]  a;
      raw = '0;
      a   = '0;
      for (int i = 0; i < 4; i++) begin
         a = mem_addr_o + 10'(i);
         raw[8*i +: 8] = sim_mem[a[9:2]][{a[1:0], 3'b000} +: 8];
      end
      case (mem_size_o)
         2'b00:   mem_rdata_i = mem_sign_o ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
         2'b01:   mem_rdata_i = mem_sign_o ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
         default: mem_rdata_i = raw;
      endcase
   end

   always @(posedge clk) begin
      if (mem_we_o) begin
         for (int i = 0; i < 4; i++) begin
            if (i < ((mem_size_o == 2'b00) ? 1 : (mem_size_o == 2'b01) ? 2 : 4)) begin
               sim_mem[10'(mem_addr_o + 10'(i)) >> 2][{2'(mem_addr_o + 10'(i)), 3'b000} +: 8] <= mem_wdata_o[8*i +: 8];
            end
         end
      end
   end

   typedef struct {
      logic [9:0]  addr;
      logic        we;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign;
   } txn_t;

   logic [7:0]  ref_mem [1024] = '{default: '0};
   txn_t        q0[$];
   txn_t        q1[$];
   txn_t        pend;
   int          gnt_log[$];
   int          checks = 0;
   int          errors = 0;
   int          last_gnt = 1;
   logic [1:0]  active = 2'b00;
   logic [1:0]  prev_req = 2'b00;
   bit          prev_gnt_any = 1'b0;
   bit          exp_valid = 1'b0;
   logic [1:0]  exp_rv;
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic [31:0] last_rdata;
   logic        last_err;
   bit          we_hi;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input txn_t t);
      logic [31:0] v;
      int n;
      n = nbytes(t.size);
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(t.addr) + i) % 1024];
      if (t.sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic void ref_store(input txn_t t);
      for (int i = 0; i < nbytes(t.size); i++) ref_mem[(int'(t.addr) + i) % 1024] = t.wdata[8*i +: 8];
   endfunction

   task automatic chk_reset_vals(input string p);
      chk({p, "_gnt"}, gnt_o, 0);
      chk({p, "_rvalid"}, rvalid_o, 0);
      chk({p, "_err"}, err_o, 0);
      chk({p, "_mem_we"}, mem_we_o, 0);
      chk({p, "_rdata"}, rdata_o, 0);
      chk({p, "_mem_addr"}, mem_addr_o, 0);
      chk({p, "_mem_wdata"}, mem_wdata_o, 0);
      chk({p, "_mem_size"}, mem_size_o, 2'b10);
      chk({p, "_mem_sign"}, mem_sign_o, 0);
   endtask

   // One cycle of the arbitration rules: a grant follows any request seen in an IDLE cycle.
   task automatic check_cycle();
      logic [1:0] exp_g;
      txn_t t;
      exp_g = 2'b00;
      if (!prev_gnt_any && prev_req != 2'b00) begin
         if (prev_req == 2'b11) exp_g = (RR && last_gnt == 0) ? 2'b10 : 2'b01;
         else exp_g = prev_req;
      end
      chk("rvalid", rvalid_o, exp_valid ? exp_rv : 2'b00);
      if (exp_valid) begin
         chk("rdata", rdata_o, exp_rdata);
         chk("err", err_o, exp_err);
         if (pend.we && pend.size != 2'b11) ref_store(pend);
      end
      if (rvalid_o != 2'b00) begin
         last_rdata = rdata_o;
         last_err   = err_o;
      end
      if (mem_we_o === 1'b1) we_hi = 1'b1;
      exp_valid = 1'b0;
      chk("gnt", gnt_o, exp_g);
      if (gnt_o != 2'b00) gnt_log.push_back(int'(gnt_o[1]));
      if (exp_g != 2'b00) begin
         if (exp_g[1]) t = q1.pop_front();
         else t = q0.pop_front();
         chk("mem_fields", {mem_addr_o, mem_wdata_o, mem_size_o, mem_sign_o},
             {t.addr, t.wdata, t.size, t.sign});
         chk("mem_we", mem_we_o, t.we && t.size != 2'b11);
         exp_valid = 1'b1;
         exp_rv    = exp_g;
         exp_err   = (t.size == 2'b11);
         exp_rdata = (t.we || t.size == 2'b11) ? 32'h0 : ref_load(t);
         pend      = t;
         last_gnt  = int'(exp_g[1]);
         active[exp_g[1]] = 1'b0;
      end else begin
         chk("mem_we_idle", mem_we_o, 0);
      end
      prev_gnt_any = (exp_g != 2'b00);
   endtask

   task automatic tick(input bit eager);
      if (!active[0] && q0.size() > 0 && (eager || $urandom_range(3) != 0)) active[0] = 1'b1;
      if (!active[1] && q1.size() > 0 && (eager || $urandom_range(3) != 0)) active[1] = 1'b1;
      req_i = active;
      if (q0.size() > 0) begin
         addr_i[0] = q0[0].addr; we_i[0] = q0[0].we; wdata_i[0] = q0[0].wdata;
         size_i[0] = q0[0].size; sign_i[0] = q0[0].sign;
      end
      if (q1.size() > 0) begin
         addr_i[1] = q1[0].addr; we_i[1] = q1[0].we; wdata_i[1] = q1[0].wdata;
         size_i[1] = q1[0].size; sign_i[1] = q1[0].sign;
      end
      prev_req = req_i;
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   task automatic run_all(input bit eager, input int budget);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || exp_valid) && n < budget) begin
         tick(eager);
         n++;
      end
      chk("run_budget", n < budget, 1'b1);
   endtask

   task automatic push(input int port, input logic [9:0] a, input logic we, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg);
      txn_t t;
      t.addr = a; t.we = we; t.wdata = wd; t.size = sz; t.sign = sg;
      if (port == 0) q0.push_back(t);
      else q1.push_back(t);
   endtask

   task automatic do_txn(input int port, input logic [9:0] a, input logic we, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg);
      push(port, a, we, wd, sz, sg);
      run_all(1'b1, 50);
   endtask

   initial begin
      int exp_order [4];
      req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0; size_i = '0; sign_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;

      do_txn(0, 10'h010, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0);
      do_txn(0, 10'h010, 1'b0, 32'h0, 2'b10, 1'b0);
      chk("ld_word", last_rdata, 32'hDEADBEEF);
      chk("ld_word_err", last_err, 1'b0);

      do_txn(1, 10'h010, 1'b1, 32'h80000000, 2'b10, 1'b0);
      do_txn(1, 10'h013, 1'b0, 32'h0, 2'b00, 1'b1);
      chk("ld_byte_signed", last_rdata, 32'hFFFFFF80);
      do_txn(1, 10'h013, 1'b0, 32'h0, 2'b00, 1'b0);
      chk("ld_byte_unsigned", last_rdata, 32'h00000080);

      gnt_log.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, 10'($urandom_range(1023)), 1'b0, 32'h0, 2'b10, 1'b0);
         push(1, 10'($urandom_range(1023)), 1'b0, 32'h0, 2'b10, 1'b0);
      end
      run_all(1'b1, 100);
      exp_order = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) chk($sformatf("grant_order_%0d", i), gnt_log[i], exp_order[i]);

      do_txn(0, 10'h020, 1'b1, 32'h0BADF00D, 2'b10, 1'b0);
      we_hi = 1'b0;
      do_txn(0, 10'h020, 1'b1, 32'h12345678, 2'b11, 1'b0);
      chk("ill_err", last_err, 1'b1);
      chk("ill_rdata", last_rdata, 32'h0);
      chk("ill_no_we", we_hi, 1'b0);
      do_txn(0, 10'h020, 1'b0, 32'h0, 2'b10, 1'b0);
      chk("ill_prior_contents", last_rdata, 32'h0BADF00D);

      do_txn(0, 10'h3FF, 1'b1, 32'hA1B2C3D4, 2'b10, 1'b0);
      chk("wrap_word255", sim_mem[255][31:24], 8'hD4);
      chk("wrap_word0", sim_mem[0][23:0], 24'hA1B2C3);
      do_txn(0, 10'h3FF, 1'b0, 32'h0, 2'b10, 1'b0);
      chk("wrap_load", last_rdata, 32'hA1B2C3D4);

      push(0, 10'h030, 1'b1, 32'h55AA55AA, 2'b10, 1'b0);
      tick(1'b1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("rst_access");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      active = 2'b00; req_i = 2'b00; prev_req = 2'b00;
      prev_gnt_any = 1'b0; exp_valid = 1'b0; last_gnt = 1;
      repeat (3) tick(1'b1);
      chk("rst_no_write", sim_mem[12], 32'h0);
      do_txn(0, 10'h030, 1'b0, 32'h0, 2'b10, 1'b0);
      chk("rst_load", last_rdata, 32'h0);

      for (int i = 0; i < 40; i++) begin
         push(int'($urandom_range(1)), 10'($urandom_range(1023)), 1'($urandom_range(1)),
              $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
      end
      run_all(1'b0, 4000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the byte-addressable data memory (256 x 32-bit, 10-bit byte address, byte/half/word sizes, signed/unsigned loads). It shares the single memory port between the core load/store unit (port 0) and a debug/DMA master (port 1). It latches the winning request, drives the memory for exactly one cycle, and returns a registered response with a one-cycle valid pulse.

## Interface
- No parameters; widths are fixed by the memory: address 10, data 32, size 2.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_i[p]  in  2 (one per port)  request; hold with fields stable until gnt_o[p]
- addr_i[p]  in  10 each  byte address
- we_i[p]  in  1 each  1 = store, 0 = load
- wdata_i[p]  in  32 each  store data
- size_i[p]  in  2 each  00 byte, 01 half, 10 word, 11 illegal
- sign_i[p]  in  1 each  1 = sign-extend load
- gnt_o[p]  out  1 each  request accepted; fields may change next cycle
- rvalid_o[p]  out  1 each  one-cycle response pulse
- rdata_o  out  32  load data; 0 for stores and errors
- err_o  out  1  qualifies rvalid_o: illegal size
- mem_addr_o  out  10  to memory byte_address
- mem_we_o  out  1  to memory write_enable
- mem_wdata_o  out  32  to memory write_data
- mem_size_o  out  2  to memory mem_size
- mem_sign_o  out  1  to memory mem_sign
- mem_rdata_i  in  32  from memory read_data (combinational)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if any req_i is high, pick a winner, latch its fields and port index, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive the mem_* outputs from the latched fields.
  - Assert gnt_o[winner].
  - Assert mem_we_o only when the latched we=1 and size != 11.
  - Capture mem_rdata_i into the rdata register when the access is a load with legal size; otherwise capture 0.
  - Set the err register to (size == 11).
  - Return to IDLE unconditionally.
- Response: rvalid_o[winner] pulses in the cycle after ACCESS. That cycle is the next IDLE, so the next request can be picked in the same cycle.
- Stores also produce rvalid_o, with rdata_o = 0 as the write acknowledge.
- Illegal size: no memory write; rvalid_o=1, err_o=1, rdata_o=0.
- Unaligned and wrap-around accesses are passed through unchanged. Address 0x3FF word access wraps into word 0; the arbiter performs no address checks.
- A losing requester stays pending and is considered at the next IDLE.

## Timing
- Request seen high in IDLE at cycle N. ACCESS and gnt_o at N+1. rvalid_o/rdata_o at N+2.
- Peak throughput: one access per 2 cycles.
- mem_* outputs are registered and stable for the whole ACCESS cycle. In IDLE they hold the last values, except mem_we_o, which is 0.
- Reset values: state IDLE; all gnt_o, rvalid_o, err_o, mem_we_o = 0; rdata_o, mem_addr_o, mem_wdata_o = 0; mem_size_o = 10; mem_sign_o = 0; round-robin pointer = port 0 preferred.
- Reset asserted during ACCESS: mem_we_o drops asynchronously, no write occurs, and no rvalid_o is produced. The in-flight transaction is lost and the requester must re-request.
- A port dropping req_i before gnt_o is legal. If the drop happens after latching, the access still completes.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. After a grant to port p, port !p has priority on the next contended cycle.
- DMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins. No pointer register is instantiated.

## Structure
- dmem_arb_pkg holds:
  - mem_size_t enum: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_ILL=2'b11
  - arb_state_t: IDLE, ACCESS
  - PORT_CPU=0, PORT_DBG=1
  - dmem_req_t struct: addr, we, wdata, size, sign
- Sub-module dmem_arb_pick: combinational two-way picker. Inputs are the req vector and the priority pointer; outputs are a one-hot winner and a valid. The macro selects the pointer source.

## Test plan
- Port 0 word store 0xDEADBEEF at 0x010, then word load at 0x010 → gnt at N+1, rvalid_o[0] at N+2, rdata_o=0xDEADBEEF, err_o=0.
- Port 1 signed byte load at 0x013 after storing word 0x80000000 at 0x010 → rdata_o=0xFFFFFF80; with sign=0 → 0x00000080.
- Both ports request continuously, 4 grants:
  - with DMEM_ARB_ROUND_ROBIN_EN, the grant order is 0,1,0,1;
  - without it, the order is 0,0,0,0 and port 1 is never granted.
- Size 11 store of 0x12345678 at 0x020 → err_o=1, rdata_o=0, mem_we_o never high, and a following word load at 0x020 returns the prior contents.
- Word store 0xA1B2C3D4 at 0x3FF → bytes land in word 255 [31:24] and word 0 [23:0]; a word load at 0x3FF returns 0xA1B2C3D4.
- reset_n pulsed low during ACCESS of a store → no memory change, no rvalid_o, and all outputs at their reset values.
